// File: rtl/tx_engine.sv
// ============================================================================
// Module      : tx_engine
// Description : Builds one PCIe completion TLP (CplD or Cpl) per popped request
//               header and OCP response, streamed on the 64-bit AXI TX port.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tx_engine #(
  parameter int AXI_WIDTH = 64
) (
  input  logic                   user_clk,
  input  logic                   user_reset,
  input  logic [15:0]            completer_id,
  input  logic                   hdr_empty,
  input  logic [35:0]            hdr_dout,
  output logic                   hdr_rd_en,
  input  logic [1:0]             SResp,
  input  logic [31:0]            SData,
  output logic                   MRespAccept,
  output logic [AXI_WIDTH-1:0]   s_axis_tx_tdata,
  output logic [AXI_WIDTH/8-1:0] s_axis_tx_tkeep,
  output logic                   s_axis_tx_tlast,
  output logic                   s_axis_tx_tvalid,
  input  logic                   s_axis_tx_tready
);

  localparam logic [1:0] c_IDLE      = 2'd0;
  localparam logic [1:0] c_WAIT_RESP = 2'd1;
  localparam logic [1:0] c_BEAT0     = 2'd2;
  localparam logic [1:0] c_BEAT1     = 2'd3;

  localparam logic [1:0] c_RESP_NULL = 2'b00;
  localparam logic [1:0] c_RESP_DVA  = 2'b01;

  localparam logic [2:0] c_STATUS_SC = 3'b000;
  localparam logic [2:0] c_STATUS_CA = 3'b100;
  localparam logic [4:0] c_TYPE_CPL  = 5'b01010;

  logic [1:0]             r_state;
  logic [1:0]             w_next;

  // Captured request header fields
  logic [15:0]            r_req_id;
  logic [7:0]             r_tag;
  logic [2:0]             r_tc;
  logic [1:0]             r_attr;
  logic [6:0]             r_lower_addr;

  // Captured response
  logic                   r_is_data;
  logic [31:0]            r_sdata;

  logic [AXI_WIDTH-1:0]   r_tdata;
  logic [AXI_WIDTH/8-1:0] r_tkeep;
  logic                   r_tlast;
  logic                   r_tvalid;

  logic                   w_hdr_rd_en;
  logic                   w_resp_accept;
  logic                   w_resp_take;
  logic                   w_cur_data;
  logic [31:0]            w_cur_sdata;
  logic [2:0]             w_status;
  logic [31:0]            w_dw0;
  logic [31:0]            w_dw1;
  logic [31:0]            w_dw2;
  logic [AXI_WIDTH-1:0]   w_tdata_nxt;
  logic [AXI_WIDTH/8-1:0] w_tkeep_nxt;
  logic                   w_tlast_nxt;
  logic                   w_tvalid_nxt;

  // State register
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:      if (!hdr_empty)           w_next = c_WAIT_RESP;
      c_WAIT_RESP: if (SResp != c_RESP_NULL) w_next = c_BEAT0;
      c_BEAT0:     if (s_axis_tx_tready)     w_next = c_BEAT1;
      c_BEAT1:     if (s_axis_tx_tready)     w_next = c_IDLE;
      default:                               w_next = c_IDLE;
    endcase
  end

  // The response is used directly on the cycle it is accepted, so BEAT0 data
  // can be registered together with the transition out of WAIT_RESP.
  assign w_resp_take = (r_state == c_WAIT_RESP) && (SResp != c_RESP_NULL);
  assign w_cur_data  = (r_state == c_WAIT_RESP) ? (SResp == c_RESP_DVA) : r_is_data;
  assign w_cur_sdata = (r_state == c_WAIT_RESP) ? SData : r_sdata;
  assign w_status    = w_cur_data ? c_STATUS_SC : c_STATUS_CA;

  assign w_dw0 = {(w_cur_data ? 3'b010 : 3'b000), c_TYPE_CPL, 1'b0, r_tc, 4'b0000,
                  1'b0, 1'b0, r_attr, 2'b00, (w_cur_data ? 10'd1 : 10'd0)};
  assign w_dw1 = {completer_id, w_status, 1'b0, 12'd4};
  assign w_dw2 = {r_req_id, r_tag, 1'b0, r_lower_addr};

  // Output logic: FIFO/OCP handshakes plus next values of the AXI registers
  always_comb begin
    w_hdr_rd_en   = 1'b0;
    w_resp_accept = 1'b0;
    w_tvalid_nxt  = 1'b0;
    w_tlast_nxt   = 1'b0;
    w_tkeep_nxt   = '0;
    w_tdata_nxt   = '0;
    if (!user_reset) begin
      w_hdr_rd_en   = (r_state == c_IDLE) && !hdr_empty;
      w_resp_accept = (r_state == c_WAIT_RESP);
    end
    case (w_next)
      c_BEAT0: begin
        w_tvalid_nxt = 1'b1;
        w_tkeep_nxt  = 8'hFF;
        w_tdata_nxt  = {w_dw1, w_dw0};
      end
      c_BEAT1: begin
        w_tvalid_nxt = 1'b1;
        w_tlast_nxt  = 1'b1;
        if (w_cur_data) begin
          w_tkeep_nxt = 8'hFF;
          w_tdata_nxt = {w_cur_sdata, w_dw2};
        end else begin
          w_tkeep_nxt = 8'h0F;
          w_tdata_nxt = {32'h0000_0000, w_dw2};
        end
      end
      default: ;
    endcase
  end

  // Capture registers and registered AXI outputs
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      r_req_id     <= '0;
      r_tag        <= '0;
      r_tc         <= '0;
      r_attr       <= '0;
      r_lower_addr <= '0;
      r_is_data    <= 1'b0;
      r_sdata      <= '0;
      r_tdata      <= '0;
      r_tkeep      <= '0;
      r_tlast      <= 1'b0;
      r_tvalid     <= 1'b0;
    end else begin
      if (w_hdr_rd_en) begin
        {r_req_id, r_tag, r_tc, r_attr, r_lower_addr} <= hdr_dout;
      end
      if (w_resp_take) begin
        r_is_data <= (SResp == c_RESP_DVA);
        r_sdata   <= (SResp == c_RESP_DVA) ? SData : 32'h0000_0000;
      end
      r_tdata  <= w_tdata_nxt;
      r_tkeep  <= w_tkeep_nxt;
      r_tlast  <= w_tlast_nxt;
      r_tvalid <= w_tvalid_nxt;
    end
  end

  assign hdr_rd_en        = w_hdr_rd_en;
  assign MRespAccept      = w_resp_accept;
  assign s_axis_tx_tdata  = r_tdata;
  assign s_axis_tx_tkeep  = r_tkeep;
  assign s_axis_tx_tlast  = r_tlast;
  assign s_axis_tx_tvalid = r_tvalid;

endmodule

`default_nettype wire
